// File: rtl/cpu_pkg.sv
// Shared CPU constants: default datapath widths, NOP encoding and a small
// saturating-add helper used by the fetch queue drop counter.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam int DROP_W = 8;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Adds b to an 8-bit counter, clamping at 255.
  function automatic logic [7:0] sat_add_u8(input logic [7:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {9'd0, a} + {1'b0, b};
    return (sum > 17'd255) ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/fq_regfile.sv
// Fetch queue entry storage: one synchronous write port, one async read port.
// Contents are never reset; validity is tracked by the queue's pointers.
module fq_regfile #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [DATA_W-1:0] wr_inst,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [DATA_W-1:0] rd_inst
);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];

  // Write the offered PC/instruction pair into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[wr_addr]   <= wr_pc;
      inst_mem[wr_addr] <= wr_inst;
    end
  end

  assign rd_pc   = pc_mem[rd_addr];
  assign rd_inst = inst_mem[rd_addr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between IF and ID. Holds up to DEPTH PC/instruction
// pairs, optionally passes words straight through when empty, and counts
// entries thrown away by redirects.
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int DATA_W = INST_W,
  parameter int ADDR_W = XLEN,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 0
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     in_valid,
  input  logic [ADDR_W-1:0]        in_pc,
  input  logic [DATA_W-1:0]        in_inst,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [ADDR_W-1:0]        out_pc,
  output logic [DATA_W-1:0]        out_inst,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DROP_W-1:0]        drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam bit BYP_EN = (BYPASS != 0);

  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, empty, bypass_sel, do_enq, do_deq;
  logic [ADDR_W-1:0] head_pc;
  logic [DATA_W-1:0] head_inst;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  // A redirect cancels the pass-through word along with everything queued.
  assign bypass_sel = BYP_EN && empty && !flush;

  assign in_ready  = !full && !Reset;
  assign out_valid = !Reset && (!empty || (bypass_sel && in_valid));

  // A bypassed word that ID takes immediately is never written to storage.
  assign do_enq = in_valid && in_ready && !flush && !(bypass_sel && out_ready);
  assign do_deq = out_valid && out_ready && !empty && !flush;

  fq_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_regfile (
    .clk     (Clock),
    .wr_en   (do_enq),
    .wr_addr (wr_ptr),
    .wr_pc   (in_pc),
    .wr_inst (in_inst),
    .rd_addr (rd_ptr),
    .rd_pc   (head_pc),
    .rd_inst (head_inst)
  );

  // Present the head entry (or the pass-through word), NOP when nothing is valid.
  always_comb begin
    out_pc   = '0;
    out_inst = DATA_W'(NOP_INST);
    if (out_valid) begin
      if (empty) begin
        out_pc   = in_pc;
        out_inst = in_inst;
      end else begin
        out_pc   = head_pc;
        out_inst = head_inst;
      end
    end
  end

  // Pointer, occupancy and drop counter update; reset beats flush beats traffic.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= sat_add_u8(drop_cnt, 16'(count));
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + 1'b1;
      if (do_deq) rd_ptr <= rd_ptr + 1'b1;
      case ({do_enq, do_deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: one instance without bypass, one with bypass,
// driven by the same stimulus. Each instance has its own scoreboard queue
// modelling queue contents; a negedge monitor pops on every handshake.
module tb_if_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_pc = '0;
  logic [31:0] in_inst = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic [1:0]       in_ready_w;
  logic [1:0]       out_valid_w;
  logic [1:0][31:0] out_pc_w;
  logic [1:0][31:0] out_inst_w;
  logic [1:0][2:0]  count_w;
  logic [1:0][7:0]  drop_w;

  int   checks = 0;
  int   errors = 0;
  ent_t sb0[$];
  ent_t sb1[$];
  int   drop_m[2];
  ent_t mon_e;

  always #5 Clock = ~Clock;

  if_fetch_queue #(.DEPTH(DEPTH), .BYPASS(0)) u_q0 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready_w[0]), .out_valid(out_valid_w[0]), .out_pc(out_pc_w[0]),
    .out_inst(out_inst_w[0]), .out_ready(out_ready), .flush(flush),
    .count(count_w[0]), .drop_cnt(drop_w[0])
  );

  if_fetch_queue #(.DEPTH(DEPTH), .BYPASS(1)) u_q1 (
    .Clock(Clock), .Reset(Reset), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready_w[1]), .out_valid(out_valid_w[1]), .out_pc(out_pc_w[1]),
    .out_inst(out_inst_w[1]), .out_ready(out_ready), .flush(flush),
    .count(count_w[1]), .drop_cnt(drop_w[1])
  );

  function automatic int sb_size(input int i);
    return (i == 0) ? sb0.size() : sb1.size();
  endfunction

  function automatic ent_t sb_pop(input int i);
    if (i == 0) return sb0.pop_front();
    return sb1.pop_front();
  endfunction

  task automatic sb_push(input int i, input ent_t e);
    if (i == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic sb_clear(input int i);
    if (i == 0) sb0.delete();
    else sb1.delete();
  endtask

  task automatic chk(input string name, input int dut, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, dut, act, exp);
    end
  endtask

  // Monitor: every accepted output word must be the oldest expected entry.
  always @(negedge Clock) begin
    for (int i = 0; i < 2; i++) begin
      if (!Reset && !flush && out_valid_w[i] && out_ready) begin
        if (sb_size(i) == 0) begin
          chk("spurious_out_valid", i, 32'(out_valid_w[i]), 32'd0);
        end else begin
          mon_e = sb_pop(i);
          chk("out_pc", i, out_pc_w[i], mon_e.pc);
          chk("out_inst", i, out_inst_w[i], mon_e.inst);
        end
      end
    end
  end

  // One cycle of stimulus: drive, check visible state against the model,
  // then advance the model to what the coming edge should produce.
  task automatic step(input logic v, input logic [31:0] pc, input logic ordy,
                      input logic fl, input logic rst);
    logic exp_ir, exp_ov;
    int   sz;
    ent_t e;
    @(posedge Clock);
    #2;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = $urandom;
    out_ready = ordy;
    flush     = fl;
    Reset     = rst;
    #1;
    for (int i = 0; i < 2; i++) begin
      sz     = sb_size(i);
      exp_ir = !rst && (sz < DEPTH);
      exp_ov = !rst && ((sz > 0) || (i == 1 && v && !fl));
      chk("in_ready", i, 32'(in_ready_w[i]), 32'(exp_ir));
      chk("out_valid", i, 32'(out_valid_w[i]), 32'(exp_ov));
      chk("count", i, 32'(count_w[i]), sz);
      chk("drop_cnt", i, 32'(drop_w[i]), drop_m[i]);
      if (!exp_ov) begin
        chk("nop_pc", i, out_pc_w[i], 32'd0);
        chk("nop_inst", i, out_inst_w[i], 32'd0);
      end
      if (rst) begin
        sb_clear(i);
        drop_m[i] = 0;
      end else if (fl) begin
        drop_m[i] = (drop_m[i] + sz > 255) ? 255 : drop_m[i] + sz;
        sb_clear(i);
      end else if (v && sz < DEPTH) begin
        e.pc   = pc;
        e.inst = in_inst;
        sb_push(i, e);
      end
    end
  endtask

  initial begin
    drop_m[0] = 0;
    drop_m[1] = 0;

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

    // Fill to DEPTH with ID stalled; the fifth offer must be refused.
    for (int k = 0; k < 4; k++) step(1'b1, 32'(k * 4), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0);

    // Drain in order, then idle with NOP outputs.
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Steady-state flow at count 2 across pointer wrap.
    step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step(1'b1, 32'(32'h108 + k * 4), 1'b1, 1'b0, 1'b0);

    // Flush at count 3 with traffic on both sides.
    step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h204, 1'b1, 1'b1, 1'b0);

    // Pass-through on an empty queue.
    step(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Build drop_cnt=5, count=2, then a one-cycle reset.
    step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h308, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h30C, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Drive drop_cnt into saturation.
    for (int r = 0; r < 70; r++) begin
      for (int k = 0; k < 4; k++) step(1'b1, 32'(32'h1000 + k * 4), 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 99) < 70, $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 4,
           $urandom_range(0, 199) == 0);
    end

    step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge Clock);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
